// File: rtl/systolic_tile_feeder_if.sv
`default_nettype none
// ============================================================
// Interface : systolic_tile_feeder_if
// CSR slave, memory read master and three stream sources of the feeder.
// Revision  : 1.0
// ============================================================
interface systolic_tile_feeder_if;
  logic [7:0]   csr_address;
  logic         csr_write;
  logic [31:0]  csr_writedata;
  logic         csr_read;
  logic [31:0]  csr_readdata;

  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_waitrequest;
  logic [255:0] mem_readdata;
  logic         mem_readdatavalid;

  logic [31:0]  st_instr_data;
  logic         st_instr_valid;
  logic         st_instr_ready;

  logic [255:0] st_rows_data;
  logic         st_rows_valid;
  logic         st_rows_ready;

  logic [255:0] st_cols_data;
  logic         st_cols_valid;
  logic         st_cols_ready;

  logic         irq;

  modport master (
    input  csr_address, csr_write, csr_writedata, csr_read,
    output csr_readdata,
    output mem_address, mem_read,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid,
    output st_instr_data, st_instr_valid,
    input  st_instr_ready,
    output st_rows_data, st_rows_valid,
    input  st_rows_ready,
    output st_cols_data, st_cols_valid,
    input  st_cols_ready,
    output irq
  );

  modport slave (
    output csr_address, csr_write, csr_writedata, csr_read,
    input  csr_readdata,
    input  mem_address, mem_read,
    output mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  st_instr_data, st_instr_valid,
    output st_instr_ready,
    input  st_rows_data, st_rows_valid,
    output st_rows_ready,
    input  st_cols_data, st_cols_valid,
    output st_cols_ready,
    input  irq
  );
endinterface
`default_nettype wire

// File: rtl/systolic_tile_feeder.sv
`default_nettype none
// ============================================================
// Module   : systolic_tile_feeder
// Fetches per-beat column/row words from memory and presents them to
// a systolic array. Define SYS_FEEDER_PERF_EN to add the STALL_CNT counter.
// Revision : 1.0
// ============================================================
module systolic_tile_feeder (
  input  logic                   CLOCK,
  input  logic                   reset,
  systolic_tile_feeder_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INSTR   = 2'd1,
    S_FETCH   = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  localparam logic [5:0] C_MAX_DIM = 6'd32;

  state_t       r_state, w_state_next;
  logic [31:0]  r_row_base, r_col_base, r_row_base_l, r_col_base_l;
  logic [11:0]  r_dims;
  logic [5:0]   r_n_cols, r_n_rows, r_k;
  logic         r_sel_row, r_req, r_pending;
  logic         r_cols_valid, r_rows_valid, r_done, r_err;
  logic [255:0] r_col_data, r_row_data;
  logic [31:0]  r_csr_rdata, w_csr_rdata, w_addr;
  logic [5:0]   w_dim_cols, w_dim_rows, w_max, w_k_inc;
  logic         w_start, w_dims_zero, w_accept, w_reject;
  logic         w_need_col, w_need_row, w_last_beat, w_fetch_done, w_beat_done;

  function automatic logic [5:0] clamp_dim(input logic [5:0] v);
    return (v > C_MAX_DIM) ? C_MAX_DIM : v;
  endfunction

  assign w_start     = bus.csr_write && (bus.csr_address == 8'd0) && bus.csr_writedata[0];
  assign w_dim_cols  = clamp_dim(r_dims[5:0]);
  assign w_dim_rows  = clamp_dim(r_dims[11:6]);
  assign w_dims_zero = (r_dims[5:0] == 6'd0) || (r_dims[11:6] == 6'd0);
  assign w_accept    = w_start && (r_state == S_IDLE) && !w_dims_zero;
  assign w_reject    = w_start && (r_state == S_IDLE) && w_dims_zero;

  assign w_need_col   = r_k < r_n_cols;
  assign w_need_row   = r_k < r_n_rows;
  assign w_max        = (r_n_cols > r_n_rows) ? r_n_cols : r_n_rows;
  assign w_last_beat  = (r_k == w_max - 6'd1);
  assign w_k_inc      = r_k + 6'd1;
  assign w_addr       = (r_sel_row ? r_row_base_l : r_col_base_l) + {26'd0, r_k};
  // A column read that still needs its row read is not the end of the fetch.
  assign w_fetch_done = r_pending && bus.mem_readdatavalid && (r_sel_row || !w_need_row);
  assign w_beat_done  = (!r_cols_valid || bus.st_cols_ready) &&
                        (!r_rows_valid || bus.st_rows_ready);

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_INSTR;
      S_INSTR:   if (bus.st_instr_ready) w_state_next = S_FETCH;
      S_FETCH:   if (w_fetch_done) w_state_next = S_PRESENT;
      S_PRESENT: if (w_beat_done) w_state_next = w_last_beat ? S_IDLE : S_FETCH;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_row_base <= '0;
      r_col_base <= '0;
      r_dims     <= '0;
    end else if (bus.csr_write) begin
      case (bus.csr_address)
        8'd1:    r_row_base <= bus.csr_writedata;
        8'd2:    r_col_base <= bus.csr_writedata;
        8'd3:    r_dims     <= bus.csr_writedata[11:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_row_base_l <= '0;
      r_col_base_l <= '0;
      r_n_cols     <= '0;
      r_n_rows     <= '0;
      r_k          <= '0;
      r_sel_row    <= 1'b0;
      r_req        <= 1'b0;
      r_pending    <= 1'b0;
      r_cols_valid <= 1'b0;
      r_rows_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_col_data   <= '0;
      r_row_data   <= '0;
    end else begin
      if (w_accept) begin
        r_row_base_l <= r_row_base;
        r_col_base_l <= r_col_base;
        r_n_cols     <= w_dim_cols;
        r_n_rows     <= w_dim_rows;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
      end else if (w_reject) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
      end else if (r_state == S_PRESENT && w_beat_done && w_last_beat) begin
        r_done <= 1'b1;
      end

      case (r_state)
        S_INSTR: begin
          if (bus.st_instr_ready) begin
            r_k       <= '0;
            r_sel_row <= 1'b0;
            r_req     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (r_req && !bus.mem_waitrequest) begin
            r_req     <= 1'b0;
            r_pending <= 1'b1;
          end
          if (r_pending && bus.mem_readdatavalid) begin
            r_pending <= 1'b0;
            if (r_sel_row) r_row_data <= bus.mem_readdata;
            else           r_col_data <= bus.mem_readdata;
            if (!r_sel_row && w_need_row) begin
              r_sel_row <= 1'b1;
              r_req     <= 1'b1;
            end else begin
              r_cols_valid <= w_need_col;
              r_rows_valid <= w_need_row;
            end
          end
        end
        S_PRESENT: begin
          if (bus.st_cols_ready) r_cols_valid <= 1'b0;
          if (bus.st_rows_ready) r_rows_valid <= 1'b0;
          if (w_beat_done && !w_last_beat) begin
            r_k       <= w_k_inc;
            r_sel_row <= !(w_k_inc < r_n_cols);
            r_req     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SYS_FEEDER_PERF_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == S_PRESENT) &&
                    ((r_cols_valid && !bus.st_cols_ready) || (r_rows_valid && !bus.st_rows_ready))) ||
                   ((r_state == S_FETCH) && bus.mem_waitrequest);

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset)                                       r_stall_cnt <= '0;
    else if (w_accept)                               r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
`endif

  always_comb begin
    w_csr_rdata = '0;
    case (bus.csr_address)
      8'd0:    w_csr_rdata = {28'd0, r_err, r_done, (r_state != S_IDLE), 1'b0};
      8'd1:    w_csr_rdata = r_row_base;
      8'd2:    w_csr_rdata = r_col_base;
      8'd3:    w_csr_rdata = {20'd0, r_dims};
`ifdef SYS_FEEDER_PERF_EN
      8'd4:    w_csr_rdata = r_stall_cnt;
`endif
      default: w_csr_rdata = '0;
    endcase
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) r_csr_rdata <= '0;
    else       r_csr_rdata <= bus.csr_read ? w_csr_rdata : 32'd0;
  end

  assign bus.csr_readdata   = r_csr_rdata;
  assign bus.mem_read       = r_req;
  assign bus.mem_address    = r_req ? w_addr : 32'd0;
  assign bus.st_instr_valid = (r_state == S_INSTR);
  assign bus.st_instr_data  = (r_state == S_INSTR) ? {20'd0, r_n_rows, r_n_cols} : 32'd0;
  assign bus.st_cols_valid  = r_cols_valid;
  assign bus.st_cols_data   = r_col_data;
  assign bus.st_rows_valid  = r_rows_valid;
  assign bus.st_rows_data   = r_row_data;
  assign bus.irq            = r_done;
endmodule
`default_nettype wire
